// File: rtl/mont_mul_issue.sv
// Operand issue stage for montgomery_reduce: 4-deep operand FIFO, 2-stage multiply, en strobe.
// Define MONT_PRECHECK_EN to flag operands outside [0, 2Q) through the sticky err output.
module mont_mul_issue #(
  parameter int Q     = 3329,
  parameter int A_W   = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [A_W-1:0]   b,
  input  logic             hold,
  output logic [2*A_W-1:0] X,
  output logic             en,
  output logic [9:0]       issue_cnt,
  output logic             busy,
  output logic             err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*A_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [A_W-1:0]   s1_a_reg, s1_b_reg;
  logic             s1_v_reg;
  logic [2*A_W-1:0] x_reg;
  logic             en_reg;
  logic [9:0]       issue_cnt_reg;
  logic [2*A_W-1:0] prod;
  logic             full, empty, push, pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !hold;
  assign prod     = (2*A_W)'(s1_a_reg) * (2*A_W)'(s1_b_reg);

  // Storage and head read carry no reset so the array maps onto RAM with a registered read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {a, b};
    if (pop)
      {s1_a_reg, s1_b_reg} <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      s1_v_reg      <= 1'b0;
      x_reg         <= '0;
      en_reg        <= 1'b0;
      issue_cnt_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      s1_v_reg      <= pop;
      x_reg         <= s1_v_reg ? prod : '0;
      en_reg        <= s1_v_reg;
      // Counts the pulse being launched at this edge; wraps naturally at 1024.
      issue_cnt_reg <= issue_cnt_reg + 10'(s1_v_reg);
    end
  end

`ifdef MONT_PRECHECK_EN
  localparam logic [A_W-1:0] LIM = A_W'(2*Q);
  logic err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else if (push && (a >= LIM || b >= LIM))
      err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign X         = x_reg;
  assign en        = en_reg;
  assign issue_cnt = issue_cnt_reg;
  assign busy      = !empty || s1_v_reg || en_reg;
endmodule

// File: tb/tb_mont_mul_issue.sv
// Directed bench for mont_mul_issue: latency, streaming, hold backpressure, reset flush, wrap, err.
module tb_mont_mul_issue;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, hold;
  logic [12:0] a, b;
  logic [25:0] X;
  logic        en, busy, err;
  logic [9:0]  issue_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int base;
  logic [31:0] exp_q[$];

  mont_mul_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .hold(hold), .X(X), .en(en),
    .issue_cnt(issue_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Applies inputs for one cycle; records the pair as expected output if it will be accepted.
  task automatic drive(input logic v, input logic [12:0] aa, input logic [12:0] bb);
    a = aa;
    b = bb;
    in_valid = v;
    if (v && in_ready && rst_n) begin
      exp_q.push_back(32'(aa) * 32'(bb));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    hold = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 13'd0, 13'd0);
      if (!busy) break;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every en pulse must carry the oldest outstanding product.
  always @(posedge clk) begin
    #1;
    if (en === 1'b1) begin
      if (exp_q.size() == 0)
        check("spurious_en", 32'(en), 32'd0);
      else
        check("x_order", 32'(X), exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_en", 32'(en), 0);
    check("rst_x", 32'(X), 0);
    check("rst_cnt", 32'(issue_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(in_ready), 1);

    // Stream 512 pairs back to back; first pair is the 2Q-1 corner.
    for (int i = 0; i < 512; i++) begin
      if (i == 0) drive(1'b1, 13'd6657, 13'd6657);
      else        drive(1'b1, 13'((i * 37) % 6658), 13'((i * 91 + 5) % 6658));
      if (i == 1) check("lat_en_e1", 32'(en), 0);
      if (i == 2) check("lat_x_e2", 32'(X), 32'd44315649);
      if (i >= 2) check("stream_en", 32'(en), 1);
    end
    drive(1'b0, 13'd0, 13'd0);
    check("tail_en1", 32'(en), 1);
    drive(1'b0, 13'd0, 13'd0);
    check("tail_en2", 32'(en), 1);
    drive(1'b0, 13'd0, 13'd0);
    check("tail_en_off", 32'(en), 0);
    drain();
    check("cnt_512", 32'(issue_cnt), 32'd512);
    check("err_inrange", 32'(err), 0);

    // Hold for 10 cycles while offering 6 pairs: only 4 fit.
    hold = 1'b1;
    base = n_acc;
    for (int i = 0; i < 6; i++)
      drive(1'b1, 13'(i + 1), 13'(i + 100));
    check("hold_accepted", 32'(n_acc - base), 32'd4);
    check("hold_ready", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 13'd0, 13'd0);
    check("hold_no_en", 32'(en), 0);
    check("hold_busy", 32'(busy), 1);
    hold = 1'b0;
    check("ready_before_pop", 32'(in_ready), 0);
    drive(1'b0, 13'd0, 13'd0);
    check("ready_after_pop", 32'(in_ready), 1);
    drain();
    check("cnt_516", 32'(issue_cnt), 32'd516);

    // Alternating valid with hold toggling every 3 cycles.
    for (int i = 0; i < 40; i++) begin
      hold = ((i / 3) % 2) == 1;
      drive(1'((i % 2) == 0), 13'(i * 13 + 7), 13'(6000 - i * 5));
    end
    drain();
    check("cnt_mixed", 32'(issue_cnt), 32'(n_acc % 1024));

    // Fill with hold, release: after edge B there are 3 queued and 2 in flight.
    hold = 1'b1;
    drive(1'b1, 13'd11, 13'd12);
    drive(1'b1, 13'd13, 13'd14);
    drive(1'b1, 13'd15, 13'd16);
    drive(1'b1, 13'd17, 13'd18);
    hold = 1'b0;
    drive(1'b1, 13'd19, 13'd20);
    drive(1'b1, 13'd19, 13'd20);
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(in_ready), 0);
    drive(1'b0, 13'd0, 13'd0);
    rst_n = 1'b1;
    exp_q.delete();
    n_acc = 0;
    check("flush_en", 32'(en), 0);
    check("flush_x", 32'(X), 0);
    check("flush_cnt", 32'(issue_cnt), 0);
    check("flush_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 13'd0, 13'd0);
    check("flush_idle_busy", 32'(busy), 0);
    check("flush_idle_cnt", 32'(issue_cnt), 0);

    // 1025 pairs wrap the issue counter to 1.
    for (int i = 0; i < 1025; i++)
      drive(1'b1, 13'(i % 6658), 13'((i * 3 + 1) % 6658));
    drain();
    check("cnt_wrap", 32'(issue_cnt), 32'd1);

    // Out-of-range operand: queued and multiplied; err only when the check is built in.
    drive(1'b1, 13'd6658, 13'd1);
`ifdef MONT_PRECHECK_EN
    check("err_set", 32'(err), 1);
`else
    check("err_set", 32'(err), 0);
`endif
    drive(1'b0, 13'd0, 13'd0);
    drive(1'b0, 13'd0, 13'd0);
    check("err_pair_en", 32'(en), 1);
    check("err_pair_x", 32'(X), 32'd6658);
    drive(1'b1, 13'd5, 13'd7);
    drain();
`ifdef MONT_PRECHECK_EN
    check("err_sticky", 32'(err), 1);
`else
    check("err_sticky", 32'(err), 0);
`endif
    check("cnt_final", 32'(issue_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
